sim_sw_status_mon: RTL and testbench
====================================

Name: sim_sw_status_mon

Overview:
Multi-channel software test-status and console monitor for top-level simulation benches. It snoops a write-only bus into a simulation-only address window. Each of NumCh channels (one per hart or SW agent) gets a status word and a console byte port. The block runs a per-channel state machine over the OpenTitan SW status codes, buffers console bytes in a FIFO, and runs an inactivity timeout. Aggregate done/pass/timeout outputs let the bench end the run with $finish.

Parameters:
NumCh, 2, number of monitored channels (1..16)
AddrW, 32, snoop address width
ConFifoDepth, 16, console FIFO entries (>=2)
TimeoutCycles, 0, inactivity limit in clk_i cycles; 0 disables the timeout
EarlyFail, 1, 1: done_o asserts on the first failing channel; 0: done_o waits for every channel to be terminal

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_addr_i  in  AddrW  window base, 8-byte aligned, quasi-static
wr_valid_i  in  1  snooped write strobe, single cycle
wr_addr_i  in  AddrW  snooped byte address
wr_data_i  in  32  snooped write data
chan_state_o  out  NumCh*2  per-channel state, encoded as chan_state_e
done_o  out  1  run complete
passed_o  out  1  all channels passed; valid while done_o is high
timeout_o  out  1  sticky inactivity timeout
con_valid_o  out  1  console byte available
con_ready_i  in  1  console consumer ready
con_data_o  out  8  console byte
con_chan_o  out  $clog2(NumCh) (min 1)  source channel of con_data_o
con_overflow_o  out  1  sticky: a console byte was dropped

Behaviour:
- Reset: clk_i only, rst_ni asynchronous active-low. During reset all outputs are 0, every channel is IDLE and the FIFO is empty. Reset mid-run discards FIFO contents and clears every sticky flag.
- Window decode. off = wr_addr_i - start_addr_i. A write hits when wr_valid_i=1 and off < NumCh*8.
  - ch = off[AddrW-1:3].
  - off[2]=0 is a status write; off[2]=1 is a console write.
  - off[1:0] is ignored.
  - Writes outside the window are ignored.
- Status codes use wr_data_i[15:0]: InTest=16'h4354, InWfi=16'h1d1e, Passed=16'h900d, Failed=16'hbaad. Any other code is ignored.
- Channel FSM, one per channel. States: IDLE, RUN, PASS, FAIL.
  - IDLE/RUN + InTest or InWfi -> RUN.
  - IDLE/RUN + Passed -> PASS.
  - IDLE/RUN + Failed -> FAIL.
  - PASS and FAIL are terminal. Later writes to a terminal channel are ignored until reset.
  - Latency: a write accepted at cycle N is reflected on chan_state_o at N+1.
- Aggregates are combinational from registered state.
  - all_term = every channel in PASS or FAIL.
  - any_fail = some channel in FAIL.
  - done_o = all_term | timeout_o | (EarlyFail & any_fail).
  - passed_o = done_o & every channel in PASS & !timeout_o.
- Timeout:
  - Counter width is $clog2(TimeoutCycles+1).
  - It clears on reset and on every accepted status write with a recognised code.
  - It increments each cycle while at least one channel is RUN and done_o=0, and saturates.
  - When it reaches TimeoutCycles, timeout_o sets and stays set. All channel states freeze.
  - With TimeoutCycles=0 the counter logic is absent and timeout_o is tied to 0.
- Console path:
  - A console write pushes {ch, wr_data_i[7:0]} into the FIFO. Push is accepted even for terminal channels.
  - FIFO is full and no pop in the same cycle: the byte is dropped and con_overflow_o sets (sticky).
  - FIFO is full with a simultaneous pop: the push is accepted.
  - Output is a valid/ready handshake, popped when con_valid_o & con_ready_i.
  - Data is held stable while valid and not ready. First-word latency is 1 cycle.
  - Order across channels is the snoop order.
- No X propagation: decode is qualified by wr_valid_i.

Decomposition:
- sim_sw_status_pkg holds:
  - the sw_status_e codes (InTest, InWfi, Passed, Failed);
  - chan_state_e (IDLE=0, RUN=1, PASS=2, FAIL=3);
  - the con_entry_t struct {chan, data};
  - the ChanStride=8 constant.
- Console buffering is one sub-module, prim_fifo_sync, with Width=$bits(con_entry_t), Depth=ConFifoDepth and Pass=0.
- Window decode, the channel FSMs and the timeout counter live in sim_sw_status_mon.

Test Plan:
- start=0x1000_0000, NumCh=2. Write 0x4354 to 0x1000_0000, then 0x900d to 0x1000_0000 and 0x1000_0008 -> ch0 RUN at N+1; done_o=1 and passed_o=1 one cycle after the last write.
- EarlyFail=1. ch0 RUN, then 0xbaad to 0x1000_0008 -> chan_state_o[3:2]=FAIL, done_o=1, passed_o=0. A later 0x900d to ch1 leaves it FAIL.
- TimeoutCycles=100. ch0 gets 0x4354 and no further writes -> timeout_o=1 exactly 100 cycles later, done_o=1, passed_o=0. A write at cycle 99 instead restarts the count.
- ConFifoDepth=4, con_ready_i=0. Write bytes 'A','B','C','D','E' to 0x1000_0004 -> 'E' dropped, con_overflow_o=1. Releasing ready pops A,B,C,D in order with con_chan_o=0.
- A write to 0x1000_0010 (outside the window) and an unknown code 0x1234 to ch0 -> no state change and no timeout restart. Asserting rst_ni=0 mid-run clears every output asynchronously.

Source files
------------

// File: rtl/sim_sw_status_pkg.sv
// Shared types and constants for the simulation SW status/console monitor.
package sim_sw_status_pkg;

    localparam int unsigned ChanStride = 8;
    localparam int unsigned MaxChW     = 4;

    typedef enum logic [15:0] {
        InTest = 16'h4354,
        InWfi  = 16'h1d1e,
        Passed = 16'h900d,
        Failed = 16'hbaad
    } sw_status_e;

    typedef enum logic [1:0] {
        ChIdle = 2'd0,
        ChRun  = 2'd1,
        ChPass = 2'd2,
        ChFail = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic [MaxChW-1:0] chan;
        logic [7:0]        data;
    } con_entry_t;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous valid/ready FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module prim_fifo_sync #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    parameter bit          Pass  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             empty, full, pass_c, push, pop;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CntW'(Depth));
    assign pass_c = Pass && empty;

    assign wready_o = !full || rready_i;
    assign rvalid_o = !empty || (pass_c && wvalid_i);
    assign rdata_o  = (pass_c) ? wdata_i : mem_q[rptr_q];

    // In pass-through mode a byte consumed straight from the input is never stored.
    assign push = wvalid_i && wready_o && !(pass_c && rready_i);
    assign pop  = !empty && rready_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sim_sw_status_mon.sv
// Snoops a simulation-only write window: per-channel SW status FSMs, console FIFO and inactivity timeout.
module sim_sw_status_mon
    import sim_sw_status_pkg::*;
#(
    parameter int unsigned NumCh         = 2,
    parameter int unsigned AddrW         = 32,
    parameter int unsigned ConFifoDepth  = 16,
    parameter int unsigned TimeoutCycles = 0,
    parameter bit          EarlyFail     = 1'b1,
    localparam int unsigned ChW          = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [AddrW-1:0]   start_addr_i,
    input  logic               wr_valid_i,
    input  logic [AddrW-1:0]   wr_addr_i,
    input  logic [31:0]        wr_data_i,
    output logic [NumCh*2-1:0] chan_state_o,
    output logic               done_o,
    output logic               passed_o,
    output logic               timeout_o,
    output logic               con_valid_o,
    input  logic               con_ready_i,
    output logic [7:0]         con_data_o,
    output logic [ChW-1:0]     con_chan_o,
    output logic               con_overflow_o
);

    logic [AddrW-1:0] off;
    logic [ChW-1:0]   ch;
    logic             hit, st_we, con_we, code_ok, code_hit;
    logic             any_run, any_fail, all_term, all_pass;
    logic             timeout_c;
    logic             overflow_q, overflow_d;
    logic             fifo_wready;
    con_entry_t       con_wr, con_rd;
    chan_state_e      state_q [NumCh];
    chan_state_e      state_d [NumCh];

    // Window decode, qualified by the strobe so idle bus values never matter.
    assign off    = wr_addr_i - start_addr_i;
    assign hit    = wr_valid_i && (off < AddrW'(NumCh * ChanStride));
    assign ch     = ChW'(off[AddrW-1:3]);
    assign st_we  = hit && !off[2];
    assign con_we = hit && off[2];

    always_comb begin
        code_ok = 1'b0;
        case (wr_data_i[15:0])
            InTest, InWfi, Passed, Failed: code_ok = 1'b1;
            default:                       code_ok = 1'b0;
        endcase
    end
    assign code_hit = st_we && code_ok;

    // Per-channel status FSMs; terminal states hold, everything freezes after a timeout.
    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            state_d[i] = state_q[i];
            if (st_we && !timeout_c && (ch == ChW'(i)) &&
                (state_q[i] == ChIdle || state_q[i] == ChRun)) begin
                case (wr_data_i[15:0])
                    InTest, InWfi: state_d[i] = ChRun;
                    Passed:        state_d[i] = ChPass;
                    Failed:        state_d[i] = ChFail;
                    default:       state_d[i] = state_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCh; i++) begin
                state_q[i] <= ChIdle;
            end
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        any_run  = 1'b0;
        any_fail = 1'b0;
        all_term = 1'b1;
        all_pass = 1'b1;
        for (int i = 0; i < NumCh; i++) begin
            chan_state_o[2*i +: 2] = state_q[i];
            any_run  = any_run  | (state_q[i] == ChRun);
            any_fail = any_fail | (state_q[i] == ChFail);
            all_term = all_term & (state_q[i] == ChPass || state_q[i] == ChFail);
            all_pass = all_pass & (state_q[i] == ChPass);
        end
    end

    assign timeout_o = timeout_c;
    assign done_o    = all_term || timeout_c || (EarlyFail && any_fail);
    assign passed_o  = done_o && all_pass && !timeout_c;

    if (TimeoutCycles > 0) begin : g_timeout
        localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            to_q, to_d;

        // Saturating inactivity counter, restarted by any recognised status write.
        always_comb begin
            cnt_d = cnt_q;
            to_d  = to_q;
            if (code_hit) begin
                cnt_d = '0;
            end else if (any_run && !done_o && cnt_q != CntW'(TimeoutCycles)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CntW'(TimeoutCycles)) begin
                to_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                to_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                to_q  <= to_d;
            end
        end

        assign timeout_c = to_q;
    end else begin : g_no_timeout
        logic unused_to;
        assign unused_to = code_hit ^ any_run;
        assign timeout_c = 1'b0;
    end

    assign con_wr.chan = MaxChW'(ch);
    assign con_wr.data = wr_data_i[7:0];

    prim_fifo_sync #(
        .Width ($bits(con_entry_t)),
        .Depth (ConFifoDepth),
        .Pass  (1'b0)
    ) u_con_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (con_we),
        .wready_o (fifo_wready),
        .wdata_i  (con_wr),
        .rvalid_o (con_valid_o),
        .rready_i (con_ready_i),
        .rdata_o  (con_rd)
    );

    // Storage is not reset, so mask the payload while nothing is valid.
    assign con_data_o = con_valid_o ? con_rd.data : '0;
    assign con_chan_o = con_valid_o ? ChW'(con_rd.chan) : '0;

    assign overflow_d = overflow_q || (con_we && !fifo_wready);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign con_overflow_o = overflow_q;

    logic unused_bits;
    assign unused_bits = ^{wr_data_i[31:16], off[1:0]};

endmodule

// File: tb/tb_sim_sw_status_mon.sv
// Directed bench for sim_sw_status_mon: vector table plus timeout, console and async-reset sequences.
module tb_sim_sw_status_mon;

    localparam int unsigned NumCh = 2;
    localparam logic [31:0] Base  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        con_ready = 1'b1;
    logic [3:0]  chan_state;
    logic        done, passed, timeout, con_valid, con_overflow;
    logic [7:0]  con_data;
    logic [0:0]  con_chan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sim_sw_status_mon #(
        .NumCh         (NumCh),
        .AddrW         (32),
        .ConFifoDepth  (4),
        .TimeoutCycles (100),
        .EarlyFail     (1'b1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_addr_i   (Base),
        .wr_valid_i     (wr_valid),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .chan_state_o   (chan_state),
        .done_o         (done),
        .passed_o       (passed),
        .timeout_o      (timeout),
        .con_valid_o    (con_valid),
        .con_ready_i    (con_ready),
        .con_data_o     (con_data),
        .con_chan_o     (con_chan),
        .con_overflow_o (con_overflow)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  st;
        logic        done;
        logic        pass;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; the write is taken on the next posedge and we return at the following negedge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_b [4];

        vecs[0]  = '{1'b1, Base + 32'h0, 32'h4354, 4'b0001, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, Base + 32'h0, 32'h900d, 4'b0010, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, Base + 32'h8, 32'h900d, 4'b1010, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, Base + 32'h0, 32'h4354, 4'b0001, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, Base + 32'h8, 32'hbaad, 4'b1101, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, Base + 32'h8, 32'h900d, 4'b1101, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, Base + 32'h0, 32'h900d, 4'b1110, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, Base + 32'h10, 32'h900d, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, Base + 32'h0, 32'h1234, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, Base + 32'h3, 32'h4354, 4'b0001, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0fff_fff8, 32'h900d, 4'b0001, 1'b0, 1'b0};

        @(negedge clk);
        chk("rst_state", 32'(chan_state), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_valid", 32'(con_valid), 32'h0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                chk($sformatf("v%0d_rst_state", i), 32'(chan_state), 32'h0);
            end
            wr(vecs[i].addr, vecs[i].data);
            chk($sformatf("v%0d_state", i), 32'(chan_state), 32'(vecs[i].st));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("v%0d_passed", i), 32'(passed), 32'(vecs[i].pass));
            chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'h0);
        end

        // Timeout fires exactly 100 cycles after the last status write, then states freeze.
        do_reset();
        wr(Base, 32'h4354);
        wait_cyc(99);
        chk("to_99", 32'(timeout), 32'h0);
        chk("to_99_done", 32'(done), 32'h0);
        wait_cyc(1);
        chk("to_100", 32'(timeout), 32'h1);
        chk("to_100_done", 32'(done), 32'h1);
        chk("to_100_passed", 32'(passed), 32'h0);
        wr(Base, 32'h900d);
        chk("to_freeze", 32'(chan_state), 32'h1);

        // A write in cycle 99 restarts the count.
        do_reset();
        wr(Base, 32'h4354);
        wait_cyc(98);
        wr(Base, 32'h1d1e);
        wait_cyc(1);
        chk("restart_100", 32'(timeout), 32'h0);
        wait_cyc(98);
        chk("restart_m99", 32'(timeout), 32'h0);
        wait_cyc(1);
        chk("restart_m100", 32'(timeout), 32'h1);

        // Ignored writes do not restart the count.
        do_reset();
        wr(Base, 32'h4354);
        wait_cyc(49);
        wr(Base, 32'h1234);
        wr(Base + 32'h10, 32'h4354);
        chk("ign_state", 32'(chan_state), 32'h1);
        wait_cyc(48);
        chk("ign_99", 32'(timeout), 32'h0);
        wait_cyc(1);
        chk("ign_100", 32'(timeout), 32'h1);

        // Console FIFO fill, overflow, hold, pop with simultaneous push.
        do_reset();
        con_ready = 1'b0;
        wr(Base + 32'h4, 32'h41);
        chk("con_first_valid", 32'(con_valid), 32'h1);
        chk("con_first_data", 32'(con_data), 32'h41);
        wr(Base + 32'h4, 32'h42);
        wr(Base + 32'h4, 32'h43);
        wr(Base + 32'h4, 32'h44);
        chk("con_ovf_before", 32'(con_overflow), 32'h0);
        wr(Base + 32'h4, 32'h45);
        chk("con_ovf_after", 32'(con_overflow), 32'h1);
        chk("con_hold", 32'(con_data), 32'h41);
        chk("con_state", 32'(chan_state), 32'h0);
        con_ready = 1'b1;
        chk("con_pop_a", 32'(con_data), 32'h41);
        wr(Base + 32'h4, 32'h46);
        exp_b[0] = 8'h42;
        exp_b[1] = 8'h43;
        exp_b[2] = 8'h44;
        exp_b[3] = 8'h46;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("con_pop%0d_valid", k), 32'(con_valid), 32'h1);
            chk($sformatf("con_pop%0d_data", k), 32'(con_data), 32'(exp_b[k]));
            chk($sformatf("con_pop%0d_chan", k), 32'(con_chan), 32'h0);
            @(negedge clk);
        end
        chk("con_empty", 32'(con_valid), 32'h0);
        wr(Base + 32'hc, 32'h5a);
        chk("con_ch1_valid", 32'(con_valid), 32'h1);
        chk("con_ch1_data", 32'(con_data), 32'h5a);
        chk("con_ch1_chan", 32'(con_chan), 32'h1);
        @(negedge clk);
        chk("con_ch1_popped", 32'(con_valid), 32'h0);

        // Asynchronous reset mid-run clears every output without a clock edge.
        con_ready = 1'b0;
        wr(Base, 32'h900d);
        wr(Base + 32'h8, 32'hbaad);
        wr(Base + 32'h4, 32'h51);
        chk("pre_rst_state", 32'(chan_state), 32'he);
        chk("pre_rst_done", 32'(done), 32'h1);
        chk("pre_rst_valid", 32'(con_valid), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_state", 32'(chan_state), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_passed", 32'(passed), 32'h0);
        chk("arst_timeout", 32'(timeout), 32'h0);
        chk("arst_valid", 32'(con_valid), 32'h0);
        chk("arst_data", 32'(con_data), 32'h0);
        chk("arst_ovf", 32'(con_overflow), 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(con_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
